md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer beside the execute stage. It owns the HI/LO registers.
//  It iterates MULT/MULTU/DIV/DIVU one bit per cycle and services MTHI/MTLO in one cycle.
//  It raises stall back to the pipeline when a HI/LO access or a new mul/div arrives while busy.

---
 rtl/md_sequencer_pkg.sv | 30 +++
 rtl/md_sequencer_if.sv | 31 +++
 rtl/md_step.sv | 46 ++++
 rtl/md_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_md_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation and state
// encodings plus the default width and iteration count.
package md_sequencer_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITER  = MD_WIDTH;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_RUN    = 2'd1,
    MD_FINISH = 2'd2
  } md_state_t;

  // True for the ops that iterate (MULT/MULTU/DIV/DIVU).
  function automatic logic md_is_iter(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer bus.
//   master (execute stage): drives start, md_op, rs, rt, flush;
//                           observes stall, busy, done, div_by_zero, hi, lo.
//   slave  (sequencer):     the mirror image.
interface md_sequencer_if
  import md_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
);
  logic             start;
  md_op_t           md_op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, rs, rt, flush,
    input  stall, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, md_op, rs, rt, flush,
    output stall, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath on the {acc, q} pair.
//   is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i/q_i: current upper/lower halves; opnd_i: multiplicand or divisor
//   acc_o/q_o: halves after the step
// Multiply: q holds the multiplier and shifts right as product bits enter from acc.
// Divide:   q holds the dividend, shifts left as quotient bits enter at bit 0.
module md_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, opnd_i};
    shifted = {acc_i, q_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    acc_o   = acc_i;
    q_o     = q_i;
    if (is_div_i) begin
      // Partial remainder stays below the divisor, so WIDTH bits always suffice.
      if (shifted >= {1'b0, opnd_i}) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else if (q_i[0]) begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[WIDTH-1:1]};
      q_o   = {acc_i[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of md_sequencer_if (start/md_op/rs/rt/flush in;
//              stall/busy/done/div_by_zero/hi/lo out)
// Signed ops run on magnitudes; the sign is restored in the FINISH cycle.
// Busy spans the issue edge through the FINISH edge (ITER + 1 cycles).
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input logic            clk,
  input logic            rst,
  md_sequencer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(ITER) + 1;

  md_state_t        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;       // negate product / quotient
  logic             rem_neg_q, rem_neg_d; // remainder takes dividend sign
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_acc, step_q;

  // Operand preparation for a new iterative op.
  logic             op_signed;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Result formation in FINISH.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  md_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .q_o      (step_q)
  );

  always_comb begin
    op_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
    sign_a    = op_signed & bus.rs[WIDTH-1];
    sign_b    = op_signed & bus.rt[WIDTH-1];
    mag_a     = sign_a ? (~bus.rs + 1'b1) : bus.rs;
    mag_b     = sign_b ? (~bus.rt + 1'b1) : bus.rt;
  end

  always_comb begin
    prod = {acc_q, q_q};
    if (neg_q) prod = ~prod + 1'b1;
    quo = neg_q ? (~q_q + 1'b1) : q_q;
    rem = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    if (bus.flush) begin
      // Squash: drop any in-flight or incoming op, HI/LO untouched.
      state_d = MD_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (bus.start) begin
            if (md_is_iter(bus.md_op)) begin
              is_div_d  = (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);
              acc_d     = '0;
              // Divide iterates on the dividend; multiply on the multiplier.
              q_d       = is_div_d ? mag_a : mag_b;
              opnd_d    = is_div_d ? mag_b : mag_a;
              neg_d     = sign_a ^ sign_b;
              rem_neg_d = sign_a;
              div0_d    = is_div_d && (bus.rt == '0);
              cnt_d     = '0;
              busy_d    = 1'b1;
              state_d   = MD_RUN;
            end else if (bus.md_op == MD_MTHI) begin
              hi_d = bus.rs;
            end else if (bus.md_op == MD_MTLO) begin
              lo_d = bus.rs;
            end
          end
        end
        MD_RUN: begin
          acc_d = step_acc;
          q_d   = step_q;
          if (cnt_q == CntW'(ITER - 1)) begin
            state_d = MD_FINISH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MD_FINISH: begin
          if (is_div_q) begin
            // Zero divisor leaves |rs| in acc, so the remainder path yields rs.
            hi_d = rem;
            lo_d = div0_q ? '1 : quo;
            dz_d = div0_q;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = MD_IDLE;
        end
        default: begin
          state_d = MD_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.stall       = bus.start & busy_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  md_sequencer_if #(.WIDTH(32)) bus ();

  md_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference results straight from arithmetic on the operands.
  task automatic model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p  = '0;
    case (op)
      MD_MULT:  p = 64'(sa * sb);
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV, MD_DIVU: begin
        if (b == 0) begin
          dz = 1'b1;
          p  = {a, 32'hFFFF_FFFF};
        end else if (op == MD_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
      default: p = '0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endtask

  task automatic run_op(input string tag, input md_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.rs    = a;
    bus.rt    = b;
    check({tag, " stall_at_issue"}, 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edz));
    check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, " lo"}, 64'(bus.lo), 64'(elo));
    @(negedge clk);
    check({tag, " done_one_pulse"}, 64'({bus.done, bus.div_by_zero}), 64'd0);
  endtask

  task automatic move_to(input md_op_t op, input logic [31:0] v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.rs    = v;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  vec_t        vecs[6];
  logic [31:0] mhi, mlo;
  logic        mdz;

  initial begin
    int n;
    int dones;
    md_op_t op;
    logic [31:0] a, b;

    bus.start = 1'b0;
    bus.md_op = MD_MFHI;
    bus.rs    = '0;
    bus.rt    = '0;
    bus.flush = 1'b0;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{MD_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{MD_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy/done/dz", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      op = md_op_t'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd1 << $urandom_range(0, 31);
      model(op, a, b, mhi, mlo, mdz);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, mhi, mlo, mdz);
    end

    // MULT followed by a dependent MFHI held until accepted.
    model(MD_MULT, 32'h1234_5678, 32'hFEDC_BA98, mhi, mlo, mdz);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_MULT;
    bus.rs    = 32'h1234_5678;
    bus.rt    = 32'hFEDC_BA98;
    @(negedge clk);
    bus.md_op = MD_MFHI;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mfhi stall_cycles", 64'(n), 64'd33);
    check("mfhi accepted_in_done", 64'({bus.done, bus.stall}), 64'b10);
    check("mfhi hi", 64'(bus.hi), 64'(mhi));
    @(negedge clk);
    bus.start = 1'b0;
    check("mfhi no_state_change", 64'({bus.hi, bus.lo}), {mhi, mlo});
    check("mfhi not_busy", 64'(bus.busy), 64'd0);

    // MTLO / MTHI while idle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_MTLO;
    bus.rs    = 32'h1234;
    check("mtlo stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'h1234);
    check("mtlo busy/done", 64'({bus.busy, bus.done}), 64'd0);

    // flush together with start: op is dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.md_op = MD_MTHI;
    bus.rs    = 32'h5555_0000;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start hi", 64'(bus.hi), 64'(mhi));

    // Flush mid-divide.
    move_to(MD_MTHI, 32'hAAAA_AAAA);
    move_to(MD_MTLO, 32'hAAAA_AAAA);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_DIV;
    bus.rs    = 32'd1000;
    bus.rt    = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush hilo", 64'({bus.hi, bus.lo}), {32'hAAAA_AAAA, 32'hAAAA_AAAA});
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) dones++;
      @(negedge clk);
    end
    check("flush no_done", 64'(dones), 64'd0);
    check("flush hilo_later", 64'({bus.hi, bus.lo}), {32'hAAAA_AAAA, 32'hAAAA_AAAA});

    // Same again, aborted by reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_DIV;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst hilo", 64'({bus.hi, bus.lo}), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("rst no_done", 64'(dones), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
